memory_access_sequencer: RTL
============================

// Module: memory_access_sequencer
// PURPOSE
//  Sequences the unified system through program load and execution, and arbitrates the single
//  unified-memory port between the external program loader and the CPU.
//  Loader owns the port until the program is loaded; CPU owns it only while running.
//  Generates load_done and the CPU run enable, and flags protocol violations.
// PARAMETERS
//  ADDR_WIDTH    5   memory address width (32 locations)
//  DATA_WIDTH    8   memory word width
//  IDLE_TIMEOUT  4   consecutive write-free LOAD cycles before load is declared done (>=1)
// PORTS
//  clock              in   1           system clock, all state on rising edge
//  reset              in   1           synchronous, active-low reset
//  prog_write_enable  in   1           loader write strobe
//  prog_addr          in   ADDR_WIDTH  loader write address
//  prog_data_in       in   DATA_WIDTH  loader write data
//  start_execution    in   1           level: 1 = run CPU, 0 = pause
//  cpu_req            in   1           CPU memory access request
//  cpu_we             in   1           CPU access is a write
//  cpu_addr           in   ADDR_WIDTH  CPU address
//  cpu_wdata          in   DATA_WIDTH  CPU write data
//  cpu_grant          out  1           CPU access accepted this cycle
//  cpu_run            out  1           CPU enable (registered)
//  load_done          out  1           program loaded (registered)
//  mem_we             out  1           memory write enable
//  mem_addr           out  ADDR_WIDTH  memory address
//  mem_wdata          out  DATA_WIDTH  memory write data
//  write_count        out  ADDR_WIDTH+1  loader writes since reset, saturating at 2**ADDR_WIDTH
//  protocol_error     out  1           sticky violation flag
// BEHAVIOUR
//  - Reset (reset==0 at edge): state=IDLE; cpu_run, load_done, write_count, idle_cnt and
//    protocol_error are cleared. While reset==0, mem_we and cpu_grant are forced to 0
//    combinationally, so a reset cycle never writes memory.
//  - States: IDLE=0, LOAD=1, LOADED=2, RUN=3. load_done=1 in LOADED/RUN; cpu_run=1 in RUN only.
//  - Port mux (combinational, 0-cycle latency):
//    - RUN: mem_* = cpu_*; mem_we = cpu_req&cpu_we; cpu_grant = cpu_req.
//    - Other states: mem_* = prog_*; mem_we = prog_write_enable; cpu_grant=0 (ignored, no error).
//    - Memory captures the write at the same rising edge.
//  - IDLE:
//    - prog_write_enable -> LOAD (write performed).
//    - start_execution -> stay IDLE and set protocol_error.
//  - LOAD:
//    - Each write clears idle_cnt; each write-free cycle increments it.
//    - A write-free cycle with idle_cnt==IDLE_TIMEOUT-1 -> LOADED.
//    - load_done rises at the edge ending the IDLE_TIMEOUT-th idle cycle.
//    - start_execution in LOAD: ignored, sets protocol_error.
//  - LOADED:
//    - start_execution -> RUN; this takes priority over a simultaneous write, which is
//      suppressed (mem_we=0) and sets protocol_error.
//    - prog_write_enable alone -> LOAD (write performed, idle_cnt=0).
//  - RUN:
//    - start_execution==0 -> LOADED (pause; program retained).
//    - prog_write_enable -> write blocked, protocol_error set.
//  - write_count increments on every performed loader write; holds at 2**ADDR_WIDTH.
//  - Address wrap is the caller's responsibility; no range checks.
//  - protocol_error clears only on reset.
// TESTING
//  1. Hold reset=0 for 2 cycles, with cpu_req=1 cpu_we=1 and prog_write_enable=1
//     -> mem_we=0, cpu_grant=0, all outputs 0, state=IDLE.
//  2. Write 16<-42, 17<-24, 0<-0xDF on consecutive cycles, then idle
//     -> mem_we=1 for exactly 3 cycles with matching addr/data; write_count=3;
//     load_done=1 exactly 4 edges after the last write edge.
//  3. From LOADED, set start_execution=1 -> cpu_run=1 next cycle.
//     - CPU read of addr 0 -> cpu_grant=1, mem_addr=0, mem_we=0.
//     - CPU write 18<-66 -> mem_we=1, mem_addr=18, mem_wdata=66.
//  4. In RUN, assert prog_write_enable with addr 5 / data 99
//     -> mem_addr follows CPU, no loader write, protocol_error=1 and stays 1.
//     - Drop start_execution -> LOADED, cpu_run=0, load_done still 1.
//  5. start_execution=1 in IDLE -> stays IDLE, protocol_error=1.
//     - Write in LOADED -> LOAD, load_done=0 next cycle, write_count increments.
//  6. Assert reset=0 mid-RUN during a CPU write -> mem_we=0 that cycle.
//     - Next edge: state=IDLE, cpu_run=0, load_done=0, write_count=0.
//  7. Write 33 times with ADDR_WIDTH=5 -> write_count saturates at 32.

Source files
------------

// File: rtl/memory_access_sequencer.sv
// Memory access sequencer: walks the system through IDLE -> LOAD -> LOADED <-> RUN
// and multiplexes the single unified-memory port between the program loader and the CPU.
module memory_access_sequencer #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  prog_write_enable,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data_in,
    input  logic                  start_execution,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_grant,
    output logic                  cpu_run,
    output logic                  load_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH:0]   write_count,
    output logic                  protocol_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LOADED = 2'd2,
        RUN    = 2'd3
    } state_t;

    // idle_cnt only has to reach IDLE_TIMEOUT-1
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IW-1:0]       IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] WC_MAX    = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
    logic [ADDR_WIDTH:0]   write_count_q, write_count_d;
    logic                  protocol_error_q, protocol_error_d;
    logic                  cpu_run_q, load_done_q;
    logic                  loader_write;

    // Next-state, idle counter, error flag and decision whether the loader write is performed
    always_comb begin
        state_d          = state_q;
        idle_cnt_d       = idle_cnt_q;
        protocol_error_d = protocol_error_q;
        loader_write     = 1'b0;
        case (state_q)
            IDLE: begin
                if (prog_write_enable) begin
                    loader_write = 1'b1;
                    state_d      = LOAD;
                    idle_cnt_d   = '0;
                end
                if (start_execution) protocol_error_d = 1'b1;
            end
            LOAD: begin
                loader_write = prog_write_enable;
                if (prog_write_enable) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = LOADED;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
                if (start_execution) protocol_error_d = 1'b1;
            end
            LOADED: begin
                // Starting wins over a concurrent write, which is dropped and flagged
                if (start_execution) begin
                    state_d = RUN;
                    if (prog_write_enable) protocol_error_d = 1'b1;
                end else if (prog_write_enable) begin
                    loader_write = 1'b1;
                    state_d      = LOAD;
                    idle_cnt_d   = '0;
                end
            end
            RUN: begin
                if (!start_execution) state_d = LOADED;
                if (prog_write_enable) protocol_error_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        write_count_d = (loader_write && (write_count_q != WC_MAX))
                        ? write_count_q + 1'b1 : write_count_q;
    end

    // Memory port mux; a reset cycle never writes memory nor grants the CPU
    always_comb begin
        if (state_q == RUN) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_req & cpu_we;
            cpu_grant = cpu_req;
        end else begin
            mem_addr  = prog_addr;
            mem_wdata = prog_data_in;
            mem_we    = loader_write;
            cpu_grant = 1'b0;
        end
        if (!reset) begin
            mem_we    = 1'b0;
            cpu_grant = 1'b0;
        end
    end

    // State register with registered status outputs derived from the next state
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= IDLE;
            idle_cnt_q       <= '0;
            write_count_q    <= '0;
            protocol_error_q <= 1'b0;
            cpu_run_q        <= 1'b0;
            load_done_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            idle_cnt_q       <= idle_cnt_d;
            write_count_q    <= write_count_d;
            protocol_error_q <= protocol_error_d;
            cpu_run_q        <= (state_d == RUN);
            load_done_q      <= (state_d == LOADED) || (state_d == RUN);
        end
    end

    assign cpu_run        = cpu_run_q;
    assign load_done      = load_done_q;
    assign write_count    = write_count_q;
    assign protocol_error = protocol_error_q;

endmodule
